// File: rtl/cgra_top.sv
// cgra_top: 2x2 coarse-grained reconfigurable array of 16-bit PE tiles.
//
// Ports
//   clk_in            sole clock, rising edge
//   reset_in          synchronous active-high reset
//   config_addr_in    [15:8] tile ID (1..4 valid, 0 = idle), [7:0] register index
//   config_data_in    configuration write data (one write per clock, no strobe)
//   pad_in_0..3       external operands
//   pad_out_0..3      registered result of tile 1..4
//   config_read_out   (only with CGRA_CONFIG_READBACK_EN) registered readback of
//                     the addressed config register, value before this edge's write
//
// Optional feature macro: CGRA_CONFIG_READBACK_EN
//
// Tile registers: 0 OPCODE[3:0], 1 SEL_A[3:0], 2 SEL_B[3:0], 3 CONST[DATA_W-1:0]
// Select codes : 0..3 pads, 4..7 tile 1..4 outputs, 8 own CONST, else 0
// Opcodes      : 0 zero, 1 add, 2 sub, 3 mul(lo), 4 and, 5 or, 6 xor, 7 A,
//                8 A<<B[3:0], 9 A>>B[3:0], else 0

// One PE tile: config registers, operand muxes, ALU and result register.
module cgra_tile #(
    parameter int DATA_W = 16
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   wr_en,
    input  logic [7:0]             cfg_idx,
    input  logic [31:0]            cfg_data,
    input  logic [3:0][DATA_W-1:0] pads,
    input  logic [3:0][DATA_W-1:0] tiles,
    output logic [DATA_W-1:0]      result
`ifdef CGRA_CONFIG_READBACK_EN
    ,
    output logic [31:0]            rd_data
`endif
);
    typedef struct packed {
        logic [3:0]        opcode;
        logic [3:0]        sel_a;
        logic [3:0]        sel_b;
        logic [DATA_W-1:0] cst;
    } tile_cfg_t;

    tile_cfg_t         cfg;
    logic [DATA_W-1:0] op_a, op_b, alu;
    logic              unused_data;

    // Only the low data bits are stored; the rest of the bus is ignored.
    assign unused_data = ^cfg_data;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cfg <= '0;
        end else if (wr_en) begin
            case (cfg_idx)
                8'd0:    cfg.opcode <= cfg_data[3:0];
                8'd1:    cfg.sel_a  <= cfg_data[3:0];
                8'd2:    cfg.sel_b  <= cfg_data[3:0];
                8'd3:    cfg.cst    <= cfg_data[DATA_W-1:0];
                default: ;
            endcase
        end
    end

    // Tile operands come from registered outputs, so feedback has no comb loop.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (!cfg.sel_a[3])      op_a = cfg.sel_a[2] ? tiles[cfg.sel_a[1:0]] : pads[cfg.sel_a[1:0]];
        else if (cfg.sel_a == 4'd8) op_a = cfg.cst;
        if (!cfg.sel_b[3])      op_b = cfg.sel_b[2] ? tiles[cfg.sel_b[1:0]] : pads[cfg.sel_b[1:0]];
        else if (cfg.sel_b == 4'd8) op_b = cfg.cst;
    end

    always_comb begin
        alu = '0;
        case (cfg.opcode)
            4'd1:    alu = op_a + op_b;
            4'd2:    alu = op_a - op_b;
            4'd3:    alu = op_a * op_b;
            4'd4:    alu = op_a & op_b;
            4'd5:    alu = op_a | op_b;
            4'd6:    alu = op_a ^ op_b;
            4'd7:    alu = op_a;
            4'd8:    alu = op_a << op_b[3:0];
            4'd9:    alu = op_a >> op_b[3:0];
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) result <= '0;
        else          result <= alu;
    end

`ifdef CGRA_CONFIG_READBACK_EN
    always_comb begin
        rd_data = '0;
        case (cfg_idx)
            8'd0:    rd_data = {28'd0, cfg.opcode};
            8'd1:    rd_data = {28'd0, cfg.sel_a};
            8'd2:    rd_data = {28'd0, cfg.sel_b};
            8'd3:    rd_data = 32'(cfg.cst);
            default: rd_data = '0;
        endcase
    end
`endif
endmodule

module cgra_top #(
    parameter int DATA_W    = 16,
    parameter int NUM_TILES = 4
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [31:0]       config_addr_in,
    input  logic [31:0]       config_data_in,
    input  logic [DATA_W-1:0] pad_in_0,
    input  logic [DATA_W-1:0] pad_in_1,
    input  logic [DATA_W-1:0] pad_in_2,
    input  logic [DATA_W-1:0] pad_in_3,
    output logic [DATA_W-1:0] pad_out_0,
    output logic [DATA_W-1:0] pad_out_1,
    output logic [DATA_W-1:0] pad_out_2,
    output logic [DATA_W-1:0] pad_out_3
`ifdef CGRA_CONFIG_READBACK_EN
    ,
    output logic [31:0]       config_read_out
`endif
);
    logic [3:0][DATA_W-1:0]           pads;
    logic [NUM_TILES-1:0][DATA_W-1:0] tile_q;
    logic [NUM_TILES-1:0]             wr_en;
    logic [7:0]                       tile_id;
    logic                             unused_addr_hi;

    assign tile_id        = config_addr_in[15:8];
    assign unused_addr_hi = ^config_addr_in[31:16];
    assign pads           = {pad_in_3, pad_in_2, pad_in_1, pad_in_0};

`ifdef CGRA_CONFIG_READBACK_EN
    logic [NUM_TILES-1:0][31:0] rd_data;
    logic [31:0]                rd_sel;
`endif

    genvar t;
    generate
        for (t = 0; t < NUM_TILES; t++) begin : g_tile
            assign wr_en[t] = (tile_id == 8'(t + 1));
            cgra_tile #(.DATA_W(DATA_W)) u_tile (
                .clk_in   (clk_in),
                .reset_in (reset_in),
                .wr_en    (wr_en[t]),
                .cfg_idx  (config_addr_in[7:0]),
                .cfg_data (config_data_in),
                .pads     (pads),
                .tiles    (tile_q),
                .result   (tile_q[t])
`ifdef CGRA_CONFIG_READBACK_EN
                ,
                .rd_data  (rd_data[t])
`endif
            );
        end
    endgenerate

    assign pad_out_0 = tile_q[0];
    assign pad_out_1 = tile_q[1];
    assign pad_out_2 = tile_q[2];
    assign pad_out_3 = tile_q[3];

`ifdef CGRA_CONFIG_READBACK_EN
    // Tiles return 0 for out-of-range indices; unmatched tile IDs fall to 0 here.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_TILES; i++)
            if (wr_en[i]) rd_sel = rd_data[i];
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) config_read_out <= '0;
        else          config_read_out <= rd_sel;
    end
`endif
endmodule

// File: tb/tb_cgra_top.sv
module tb_cgra_top;
    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [31:0] config_addr_in, config_data_in;
    logic [15:0] pad[4];
    logic [15:0] pout[4];
`ifdef CGRA_CONFIG_READBACK_EN
    logic [31:0] config_read_out;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int unsigned m_op[4], m_sa[4], m_sb[4], m_cst[4], m_out[4];

    always #5 clk_in = ~clk_in;

    cgra_top dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .config_addr_in (config_addr_in),
        .config_data_in (config_data_in),
        .pad_in_0       (pad[0]),
        .pad_in_1       (pad[1]),
        .pad_in_2       (pad[2]),
        .pad_in_3       (pad[3]),
        .pad_out_0      (pout[0]),
        .pad_out_1      (pout[1]),
        .pad_out_2      (pout[2]),
        .pad_out_3      (pout[3])
`ifdef CGRA_CONFIG_READBACK_EN
        ,
        .config_read_out(config_read_out)
`endif
    );

    function automatic int unsigned operand(int k, int unsigned sel);
        if (sel < 4)       return pad[sel];
        else if (sel < 8)  return m_out[sel-4];
        else if (sel == 8) return m_cst[k];
        return 0;
    endfunction

    function automatic int unsigned alu(int unsigned op, int unsigned a, int unsigned b);
        longint unsigned r;
        case (op)
            1: r = a + b;
            2: r = a + 65536 - b;
            3: r = longint'(a) * longint'(b);
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = a;
            8: r = longint'(a) * (64'd1 << (b % 16));
            9: r = a / (32'd1 << (b % 16));
            default: r = 0;
        endcase
        return int'(r % 65536);
    endfunction

    // Advance one clock: model sees pre-edge config/inputs, then DUT is sampled #1 after the edge.
    task automatic tick();
        int unsigned nxt[4];
        int unsigned id, idx;
        for (int k = 0; k < 4; k++) nxt[k] = alu(m_op[k], operand(k, m_sa[k]), operand(k, m_sb[k]));
        id  = (config_addr_in >> 8) & 32'hFF;
        idx = config_addr_in & 32'hFF;
        if (reset_in) begin
            for (int k = 0; k < 4; k++) begin
                m_op[k] = 0; m_sa[k] = 0; m_sb[k] = 0; m_cst[k] = 0; nxt[k] = 0;
            end
        end else if (id >= 1 && id <= 4) begin
            case (idx)
                0: m_op[id-1]  = config_data_in & 32'hF;
                1: m_sa[id-1]  = config_data_in & 32'hF;
                2: m_sb[id-1]  = config_data_in & 32'hF;
                3: m_cst[id-1] = config_data_in & 32'hFFFF;
                default: ;
            endcase
        end
        for (int k = 0; k < 4; k++) m_out[k] = nxt[k];
        @(posedge clk_in);
        #1;
    endtask

    task automatic cfg_write(int tile, int idx, int unsigned data);
        config_addr_in = (tile << 8) | idx;
        config_data_in = data;
        tick();
        config_addr_in = 0;
        config_data_in = 0;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
    endtask

    task automatic test_reset();
        pad[0] = 16'h1234; pad[1] = 16'h00FF; pad[2] = 16'hA5A5; pad[3] = 16'h0F0F;
        reset_in = 1'b1;
        tick();
        config_addr_in = 32'h0000_0100; config_data_in = 32'h1; // OPCODE=1 during reset
        tick();
        config_addr_in = 32'h0000_0101; config_data_in = 32'h0;
        tick();
        config_addr_in = 0; config_data_in = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pout[k] !== 16'h0) begin
                errors++;
                $display("FAIL reset_pad_out_%0d: got %h expected 0000", k, pout[k]);
            end
        end
        reset_in = 1'b0;
        cfg_write(1, 2, 1); // SEL_B=1; OPCODE must still be 0
        tick();
        checks++;
        if (pout[0] !== 16'h0) begin
            errors++;
            $display("FAIL reset_write_ignored: got %h expected 0000", pout[0]);
        end
    endtask

    task automatic test_add();
        do_reset();
        cfg_write(1, 1, 0);
        cfg_write(1, 2, 1);
        cfg_write(1, 0, 1);
        pad[0] = 16'h0003; pad[1] = 16'h0004;
        tick();
        checks++;
        if (pout[0] !== 16'h0007) begin
            errors++;
            $display("FAIL add_basic: got %h expected 0007", pout[0]);
        end
        pad[0] = 16'hFFFF; pad[1] = 16'h0002;
        tick();
        checks++;
        if (pout[0] !== 16'h0001) begin
            errors++;
            $display("FAIL add_wrap: got %h expected 0001", pout[0]);
        end
    endtask

    task automatic test_chain();
        do_reset();
        cfg_write(2, 1, 4);
        cfg_write(2, 2, 8);
        cfg_write(2, 3, 2);
        cfg_write(2, 0, 3);
        cfg_write(1, 1, 8);
        cfg_write(1, 3, 16'h0010);
        cfg_write(1, 0, 7);       // edge N
        checks++;                 // tile1 still outputs 0 right after edge N
        if (pout[0] !== 16'h0000) begin
            errors++;
            $display("FAIL chain_latency0: got %h expected 0000", pout[0]);
        end
        tick();                   // edge N+1
        checks++;
        if (pout[0] !== 16'h0010 || pout[1] !== 16'h0000) begin
            errors++;
            $display("FAIL chain_hop1: got %h/%h expected 0010/0000", pout[0], pout[1]);
        end
        tick();                   // edge N+2
        checks++;
        if (pout[1] !== 16'h0020) begin
            errors++;
            $display("FAIL chain_hop2: got %h expected 0020", pout[1]);
        end
    endtask

    task automatic test_accum();
        do_reset();
        cfg_write(3, 1, 6);
        cfg_write(3, 2, 8);
        cfg_write(3, 3, 1);
        cfg_write(3, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (pout[2] !== 16'(i)) begin
                errors++;
                $display("FAIL accum_step%0d: got %h expected %h", i, pout[2], 16'(i));
            end
        end
        do_reset();
        checks++;
        if (pout[2] !== 16'h0) begin
            errors++;
            $display("FAIL accum_reset: got %h expected 0000", pout[2]);
        end
        tick();
        checks++;
        if (pout[2] !== 16'h0) begin
            errors++;
            $display("FAIL accum_after_reset: got %h expected 0000", pout[2]);
        end
    endtask

    task automatic test_ignored();
        int unsigned addrs[3] = '{32'h0000_0000, 32'h0000_0500, 32'h0000_0104};
        do_reset();
        cfg_write(1, 1, 0);
        cfg_write(1, 2, 1);
        cfg_write(1, 0, 6);       // XOR
        pad[0] = 16'h5A5A; pad[1] = 16'h0FF0;
        tick();
        for (int i = 0; i < 3; i++) begin
            config_addr_in = addrs[i];
            config_data_in = 32'hFFFF_FFFF;
            tick();
            tick();
            checks++;
            if (pout[0] !== 16'h55AA || pout[1] !== 16'h0 || pout[2] !== 16'h0 || pout[3] !== 16'h0) begin
                errors++;
                $display("FAIL ignored_addr_%h: got %h %h %h %h expected 55aa 0000 0000 0000",
                         addrs[i], pout[0], pout[1], pout[2], pout[3]);
            end
        end
        config_addr_in = 0; config_data_in = 0;
    endtask

    task automatic test_shift_timing();
        do_reset();
        cfg_write(4, 1, 2);
        cfg_write(4, 2, 3);
        cfg_write(4, 0, 8);
        pad[2] = 16'h0001; pad[3] = 16'h0014;
        tick();
        checks++;
        if (pout[3] !== 16'h0010) begin
            errors++;
            $display("FAIL shift_left: got %h expected 0010", pout[3]);
        end
        cfg_write(4, 0, 9);       // edge N: result still uses old opcode
        checks++;
        if (pout[3] !== 16'h0010) begin
            errors++;
            $display("FAIL shift_edgeN: got %h expected 0010", pout[3]);
        end
        tick();                   // edge N+1
        checks++;
        if (pout[3] !== 16'h0000) begin
            errors++;
            $display("FAIL shift_right_edgeN1: got %h expected 0000", pout[3]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) pad[k] = 16'($urandom);
            reset_in = ($urandom_range(0, 60) == 0);
            config_addr_in = ($urandom & 32'hFFFF_0000) |
                             ($urandom_range(0, 5) << 8) | $urandom_range(0, 5);
            // Bias select writes toward meaningful codes so feedback paths get exercised.
            config_data_in = $urandom;
            if ((config_addr_in & 32'hFF) inside {1, 2} && $urandom_range(0, 3) != 0)
                config_data_in = (config_data_in & 32'hFFFF_FFF0) | $urandom_range(0, 8);
            tick();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (pout[k] !== 16'(m_out[k])) begin
                    errors++;
                    $display("FAIL random_c%0d_out%0d: got %h expected %h", c, k, pout[k], 16'(m_out[k]));
                end
            end
        end
        reset_in = 1'b0;
        config_addr_in = 0;
        config_data_in = 0;
    endtask

    initial begin
        reset_in = 1'b1;
        config_addr_in = 0;
        config_data_in = 0;
        for (int k = 0; k < 4; k++) begin
            pad[k] = 0;
            m_op[k] = 0; m_sa[k] = 0; m_sb[k] = 0; m_cst[k] = 0; m_out[k] = 0;
        end
        test_reset();
        test_add();
        test_chain();
        test_accum();
        test_ignored();
        test_shift_timing();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
